// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS32 core.
// Generates per-stage stall/flush, D/E forwarding selects, and tracks
// multi-cycle divide occupancy. Exception flush has top priority, then an
// in-flight or starting divide, then load-use / branch data hazards.
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             branch_d,
    input  logic             jr_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] writereg_e,
    input  logic [REG_W-1:0] writereg_m,
    input  logic [REG_W-1:0] writereg_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             memtoreg_m,
    input  logic             div_start_e,
    input  logic             except_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             stall_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic             forwarda_d,
    output logic             forwardb_d,
    output logic [1:0]       forwarda_e,
    output logic [1:0]       forwardb_e,
    output logic             div_busy,
    output logic             div_done
);

    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] DIV = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_busy_q, div_busy_d;
    logic             div_done_q, div_done_d;

    logic       fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       lwstall, branchstall;
    logic [4:0] stall_c;   // {f,d,e,m,w}
    logic [3:0] flush_c;   // {d,e,m,w}

    // Forwarding selects; register 0 never matches. M result beats W result.
    always_comb begin
        fwd_a_e = 2'b00;
        if (rs_e != '0 && regwrite_m && writereg_m == rs_e)
            fwd_a_e = 2'b10;
        else if (rs_e != '0 && regwrite_w && writereg_w == rs_e)
            fwd_a_e = 2'b01;

        fwd_b_e = 2'b00;
        if (rt_e != '0 && regwrite_m && writereg_m == rt_e)
            fwd_b_e = 2'b10;
        else if (rt_e != '0 && regwrite_w && writereg_w == rt_e)
            fwd_b_e = 2'b01;

        fwd_a_d = (rs_d != '0) && regwrite_m && (writereg_m == rs_d);
        fwd_b_d = (rt_d != '0) && regwrite_m && (writereg_m == rt_d);
    end

    // Prioritised stall/flush generation and divide FSM next-state.
    always_comb begin
        lwstall = memtoreg_e && (writereg_e != '0) &&
                  ((writereg_e == rs_d) || (writereg_e == rt_d));
        branchstall = (branch_d || jr_d) &&
                      ((regwrite_e && (writereg_e != '0) &&
                        ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                       (memtoreg_m && (writereg_m != '0) &&
                        ((writereg_m == rs_d) || (writereg_m == rt_d))));

        stall_c    = '0;
        flush_c    = '0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_busy_d = div_busy_q;
        div_done_d = 1'b0;

        if (except_m) begin
            // Exception aborts any divide; no completion pulse is produced.
            flush_c    = '1;
            state_d    = RUN;
            cnt_d      = '0;
            div_busy_d = 1'b0;
        end else if (state_q == DIV) begin
            stall_c = 5'b11100;
            flush_c = 4'b0010;
            if (cnt_q == '0) begin
                state_d    = RUN;
                div_busy_d = 1'b0;
                div_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (div_start_e) begin
            // Start cycle counts as the first of DIV_CYCLES stall cycles.
            stall_c    = 5'b11100;
            flush_c    = 4'b0010;
            state_d    = DIV;
            cnt_d      = CNT_W'(DIV_CYCLES - 2);
            div_busy_d = 1'b1;
        end else if (lwstall || branchstall) begin
            stall_c = 5'b11000;
            flush_c = 4'b0100;
        end
    end

    // Divide FSM state, counter and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            div_busy_q <= 1'b0;
            div_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_busy_q <= div_busy_d;
            div_done_q <= div_done_d;
        end
    end

    // Outputs forced to the safe bubble pattern while reset is held.
    always_comb begin
        {stall_f, stall_d, stall_e, stall_m, stall_w} = reset ? stall_c : 5'b00000;
        {flush_d, flush_e, flush_m, flush_w}          = reset ? flush_c : 4'b1111;
        forwarda_d = reset & fwd_a_d;
        forwardb_d = reset & fwd_b_d;
        forwarda_e = reset ? fwd_a_e : 2'b00;
        forwardb_e = reset ? fwd_b_e : 2'b00;
        div_busy   = div_busy_q;
        div_done   = div_done_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic       branch_d, jr_d, regwrite_e, regwrite_m, regwrite_w;
    logic       memtoreg_e, memtoreg_m, div_start_e, except_m;
    logic       stall_f, stall_d, stall_e, stall_m, stall_w;
    logic       flush_d, flush_e, flush_m, flush_w;
    logic       forwarda_d, forwardb_d, div_busy, div_done;
    logic [1:0] forwarda_e, forwardb_e;

    int vectors = 0;
    int miscompares = 0;

    pipe_hazard_ctrl #(.DIV_CYCLES(32), .REG_W(5), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .jr_d(jr_d),
        .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .div_start_e(div_start_e), .except_m(except_m),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .stall_m(stall_m), .stall_w(stall_w),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .forwarda_d(forwarda_d), .forwardb_d(forwardb_d),
        .forwarda_e(forwarda_e), .forwardb_e(forwardb_e),
        .div_busy(div_busy), .div_done(div_done)
    );

    always #5 clk = ~clk;

    wire [4:0] stalls  = {stall_f, stall_d, stall_e, stall_m, stall_w};
    wire [3:0] flushes = {flush_d, flush_e, flush_m, flush_w};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        writereg_e = 0; writereg_m = 0; writereg_w = 0;
        branch_d = 0; jr_d = 0; regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
        memtoreg_e = 0; memtoreg_m = 0; div_start_e = 0; except_m = 0;
    endtask

    initial begin
        logic seen_done;
        idle();
        reset = 1'b0;
        // Forward-triggering inputs during reset must be masked.
        regwrite_m = 1; writereg_m = 5; rs_e = 5;
        #2;
        chk("rst_stall", 32'(stalls), 32'h00);
        chk("rst_flush", 32'(flushes), 32'hF);
        chk("rst_fwda_e", 32'(forwarda_e), 32'h0);
        chk("rst_busy", 32'(div_busy), 32'h0);
        chk("rst_done", 32'(div_done), 32'h0);

        cyc(); cyc();
        reset = 1'b1;
        idle();
        #1;
        chk("idle_stall", 32'(stalls), 32'h00);
        chk("idle_flush", 32'(flushes), 32'h0);

        // Load-use hazard
        cyc();
        memtoreg_e = 1; writereg_e = 2; rs_d = 2; #1;
        chk("lw_stall", 32'(stalls), 32'h18);
        chk("lw_flush", 32'(flushes), 32'h4);
        cyc(); idle(); #1;
        chk("lw_clear_stall", 32'(stalls), 32'h00);
        chk("lw_clear_flush", 32'(flushes), 32'h0);
        memtoreg_e = 1; writereg_e = 3; rt_d = 3; #1;
        chk("lw_rt_stall", 32'(stalls), 32'h18);
        writereg_e = 0; rt_d = 0; rs_d = 0; #1;
        chk("lw_r0_stall", 32'(stalls), 32'h00);
        chk("lw_r0_flush", 32'(flushes), 32'h0);

        // E-stage and D-stage forwarding
        cyc(); idle();
        regwrite_m = 1; regwrite_w = 1; writereg_m = 5; writereg_w = 5;
        rs_e = 5; rt_e = 5; rs_d = 5; #1;
        chk("fwda_e_m", 32'(forwarda_e), 32'h2);
        chk("fwdb_e_m", 32'(forwardb_e), 32'h2);
        chk("fwda_d_m", 32'(forwarda_d), 32'h1);
        regwrite_m = 0; #1;
        chk("fwda_e_w", 32'(forwarda_e), 32'h1);
        chk("fwda_d_off", 32'(forwarda_d), 32'h0);
        rs_e = 0; #1;
        chk("fwda_e_r0", 32'(forwarda_e), 32'h0);
        chk("fwdb_e_w", 32'(forwardb_e), 32'h1);
        regwrite_m = 1; writereg_m = 0; writereg_w = 0; rt_e = 0; rt_d = 0; rs_d = 0; #1;
        chk("fwdb_e_r0", 32'(forwardb_e), 32'h0);
        chk("fwdb_d_r0", 32'(forwardb_d), 32'h0);

        // Branch hazard: writer in E, then in M (ALU op), then a load in M
        cyc(); idle();
        branch_d = 1; rs_d = 7; regwrite_e = 1; writereg_e = 7; #1;
        chk("br_e_stall", 32'(stalls), 32'h18);
        chk("br_e_flush", 32'(flushes), 32'h4);
        cyc();
        regwrite_e = 0; writereg_e = 0; regwrite_m = 1; writereg_m = 7; #1;
        chk("br_m_stall", 32'(stalls), 32'h00);
        chk("br_m_fwda_d", 32'(forwarda_d), 32'h1);
        memtoreg_m = 1; #1;
        chk("br_ld_m_stall", 32'(stalls), 32'h18);
        branch_d = 0; jr_d = 1; #1;
        chk("jr_ld_m_stall", 32'(stalls), 32'h18);
        jr_d = 0; #1;
        chk("nobr_ld_m_stall", 32'(stalls), 32'h00);

        // Full divide: 32 stall cycles counted from the start cycle
        cyc(); idle();
        div_start_e = 1; #1;
        chk("div_start_stall", 32'(stalls), 32'h1C);
        chk("div_start_flush", 32'(flushes), 32'h2);
        chk("div_start_busy", 32'(div_busy), 32'h0);
        for (int i = 1; i <= 31; i++) begin
            cyc();
            // Data hazard present mid-divide must not change outputs.
            if (i == 10) begin memtoreg_e = 1; writereg_e = 4; rs_d = 4; end
            if (i == 11) begin memtoreg_e = 0; writereg_e = 0; rs_d = 0; end
            #1;
            chk("div_stall", 32'(stalls), 32'h1C);
            chk("div_flush", 32'(flushes), 32'h2);
            chk("div_busy", 32'(div_busy), 32'h1);
            chk("div_done_low", 32'(div_done), 32'h0);
        end
        cyc(); div_start_e = 0; #1;
        chk("div_rel_stall", 32'(stalls), 32'h00);
        chk("div_rel_flush", 32'(flushes), 32'h0);
        chk("div_rel_busy", 32'(div_busy), 32'h0);
        chk("div_rel_done", 32'(div_done), 32'h1);
        cyc(); #1;
        chk("div_after_done", 32'(div_done), 32'h0);

        // Exception at cycle 10 of a divide
        cyc(); idle();
        div_start_e = 1;
        for (int i = 0; i < 9; i++) cyc();
        except_m = 1; #1;
        chk("exc_stall", 32'(stalls), 32'h00);
        chk("exc_flush", 32'(flushes), 32'hF);
        cyc(); except_m = 0; div_start_e = 0; #1;
        chk("exc_busy", 32'(div_busy), 32'h0);
        chk("exc_done", 32'(div_done), 32'h0);
        chk("exc_run_stall", 32'(stalls), 32'h00);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (div_done) seen_done = 1'b1;
        end
        chk("exc_no_done", 32'(seen_done), 32'h0);

        // Exception coincident with a divide start in RUN
        idle(); div_start_e = 1; except_m = 1; #1;
        chk("exc_start_stall", 32'(stalls), 32'h00);
        chk("exc_start_flush", 32'(flushes), 32'hF);
        cyc(); idle(); #1;
        chk("exc_start_busy", 32'(div_busy), 32'h0);

        // Asynchronous reset mid-divide
        div_start_e = 1;
        for (int i = 0; i < 5; i++) cyc();
        chk("pre_rst_busy", 32'(div_busy), 32'h1);
        reset = 1'b0; #1;
        chk("arst_busy", 32'(div_busy), 32'h0);
        chk("arst_done", 32'(div_done), 32'h0);
        chk("arst_flush", 32'(flushes), 32'hF);
        chk("arst_stall", 32'(stalls), 32'h00);
        cyc();
        idle(); reset = 1'b1;
        memtoreg_e = 1; writereg_e = 9; rt_d = 9; #1;
        chk("post_rst_lw_stall", 32'(stalls), 32'h18);
        chk("post_rst_lw_flush", 32'(flushes), 32'h4);
        cyc(); #1;
        chk("post_rst_busy", 32'(div_busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
